// File: rtl/i2s_ext_slave.sv
// rtl/i2s_ext_slave.sv - far-end I2S slave: oversampled receive deserialiser and transmit serialiser
//
// Purpose: consumes the BCLK/LRCLK pair from the transceiver, deserialises DIN slots into
// rx_left/rx_right, and serialises tx_left/tx_right onto dout. Everything runs in the
// system clock domain by oversampling the I2S pins (clock >= 8x bclk).
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   bclk, lrclk, din    I2S inputs (lrclk low = left slot)
//   dout                serial data towards the transceiver
//   tx_left/tx_right    words to transmit; tx_ack pulses when they are latched
//   rx_left/rx_right    last received pair; rx_valid pulses when updated
//   frame_err           pulse on a slot-length violation
//   locked              high while framing is tracked (RUN)
module i2s_ext_slave #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bclk,
  input  logic              lrclk,
  input  logic              din,
  output logic              dout,
  input  logic [DATA_W-1:0] tx_left,
  input  logic [DATA_W-1:0] tx_right,
  output logic              tx_ack,
  output logic [DATA_W-1:0] rx_left,
  output logic [DATA_W-1:0] rx_right,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              locked
);

  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [CNT_W-1:0] DATA_LIM  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(SLOT_W - 1);
  // Counter value on the rise that would make bit_cnt reach 2*SLOT_W-1.
  localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(2 * SLOT_W - 2);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q;
  logic [1:0]        bclk_sync_q;
  logic [1:0]        lrclk_sync_q;
  logic [1:0]        din_sync_q;
  logic              bclk_prev_q;
  logic              ws_prev_q;
  logic              ws_seen_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] left_hold_q;
  logic              left_staged_q;
  logic [DATA_W-1:0] tx_hold_l_q;
  logic [DATA_W-1:0] tx_hold_r_q;
  logic [DATA_W-1:0] rx_left_q;
  logic [DATA_W-1:0] rx_right_q;
  logic              dout_q;
  logic              tx_ack_q;
  logic              rx_valid_q;
  logic              frame_err_q;

  logic              rise_d;
  logic              fall_d;
  logic              ws_d;
  logic              bit_d;
  logic              ws_chg_d;
  logic [DATA_W-1:0] tx_word_d;

  assign rise_d   = bclk_sync_q[1] & ~bclk_prev_q;
  assign fall_d   = ~bclk_sync_q[1] & bclk_prev_q;
  assign ws_d     = lrclk_sync_q[1];
  assign bit_d    = din_sync_q[1];
  // The very first rise after reset only seeds ws_prev_q; a change needs a real previous sample.
  assign ws_chg_d = ws_seen_q & (ws_d != ws_prev_q);
  // Shifting by bit_cnt puts the current bit at the MSB; counts >= DATA_W shift it all out to 0.
  assign tx_word_d = (ws_prev_q ? tx_hold_r_q : tx_hold_l_q) << bit_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      bclk_sync_q   <= '0;
      lrclk_sync_q  <= '0;
      din_sync_q    <= '0;
      bclk_prev_q   <= 1'b0;
      ws_prev_q     <= 1'b0;
      ws_seen_q     <= 1'b0;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      left_hold_q   <= '0;
      left_staged_q <= 1'b0;
      tx_hold_l_q   <= '0;
      tx_hold_r_q   <= '0;
      rx_left_q     <= '0;
      rx_right_q    <= '0;
      dout_q        <= 1'b0;
      tx_ack_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[0], bclk};
      lrclk_sync_q <= {lrclk_sync_q[0], lrclk};
      din_sync_q   <= {din_sync_q[0], din};
      bclk_prev_q  <= bclk_sync_q[1];
      tx_ack_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;

      if (rise_d) begin
        ws_prev_q <= ws_d;
        ws_seen_q <= 1'b1;

        // Left slot start: latch the next TX pair, regardless of slot validity.
        if (ws_chg_d && !ws_d) begin
          tx_hold_l_q <= tx_left;
          tx_hold_r_q <= tx_right;
          tx_ack_q    <= 1'b1;
        end

        case (state_q)
          HUNT: begin
            if (ws_chg_d) begin
              state_q   <= RUN;
              bit_cnt_q <= '0;
            end
          end
          RUN: begin
            if (!ws_chg_d) begin
              if (bit_cnt_q < DATA_LIM) begin
                rx_shift_q <= {rx_shift_q[DATA_W-2:0], bit_d};
              end
              if (bit_cnt_q == STUCK_LIM) begin
                // LRCLK stopped toggling: drop framing and stop driving data.
                frame_err_q   <= 1'b1;
                left_staged_q <= 1'b0;
                state_q       <= HUNT;
                bit_cnt_q     <= '0;
                tx_hold_l_q   <= '0;
                tx_hold_r_q   <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_q <= '0;
              if (bit_cnt_q != SLOT_END) begin
                // Wrong slot length: discard any staged half and resync on this edge.
                frame_err_q   <= 1'b1;
                left_staged_q <= 1'b0;
              end else if (!ws_prev_q) begin
                left_hold_q   <= rx_shift_q;
                left_staged_q <= 1'b1;
              end else if (left_staged_q) begin
                rx_left_q     <= left_hold_q;
                rx_right_q    <= rx_shift_q;
                rx_valid_q    <= 1'b1;
                left_staged_q <= 1'b0;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end

      if (state_q == HUNT) begin
        dout_q <= 1'b0;
      end else if (fall_d) begin
        dout_q <= tx_word_d[DATA_W-1];
      end
    end
  end

  assign dout      = dout_q;
  assign tx_ack    = tx_ack_q;
  assign rx_left   = rx_left_q;
  assign rx_right  = rx_right_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign locked    = (state_q == RUN);

endmodule

// File: tb/tb_i2s_ext_slave.sv
// tb/tb_i2s_ext_slave.sv - directed self-checking bench for i2s_ext_slave
module tb_i2s_ext_slave;

  localparam int HALF = 50;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        din = 1'b0;
  logic [23:0] tx_left = '0;
  logic [23:0] tx_right = '0;
  logic        dout;
  logic        tx_ack;
  logic [23:0] rx_left;
  logic [23:0] rx_right;
  logic        rx_valid;
  logic        frame_err;
  logic        locked;

  int tests_run = 0;
  int fails = 0;
  int rx_cnt = 0;
  int ferr_cnt = 0;
  int ack_cnt = 0;

  i2s_ext_slave #(.DATA_W(24), .SLOT_W(32)) dut (
    .clock(clock), .reset(reset), .bclk(bclk), .lrclk(lrclk), .din(din),
    .dout(dout), .tx_left(tx_left), .tx_right(tx_right), .tx_ack(tx_ack),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
    .frame_err(frame_err), .locked(locked)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid) rx_cnt++;
    if (frame_err) ferr_cnt++;
    if (tx_ack) ack_cnt++;
  end

  task automatic bclk_cycle(input logic lr, input logic d, output logic cap);
    lrclk = lr;
    din = d;
    #HALF;
    cap = dout;
    bclk = 1'b1;
    #HALF;
    bclk = 1'b0;
  endtask

  task automatic send_slot(input logic ws, input logic [23:0] w, input int n, output logic [31:0] cap);
    logic c;
    logic lr;
    logic d;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      lr = (i == n - 1) ? ~ws : ws;
      d = (i < 24) ? w[23 - i] : 1'b0;
      bclk_cycle(lr, d, c);
      if (i < 32) cap[31 - i] = c;
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            output logic [31:0] cl, output logic [31:0] cr);
    send_slot(1'b0, l, 32, cl);
    send_slot(1'b1, r, 32, cr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b0;
    din = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (dout !== 1'b0) begin fails++; $display("FAIL reset_dout: got %b expected 0", dout); end
    tests_run++; if (tx_ack !== 1'b0) begin fails++; $display("FAIL reset_tx_ack: got %b expected 0", tx_ack); end
    tests_run++; if (rx_left !== 24'h0) begin fails++; $display("FAIL reset_rx_left: got %h expected 0", rx_left); end
    tests_run++; if (rx_right !== 24'h0) begin fails++; $display("FAIL reset_rx_right: got %h expected 0", rx_right); end
    tests_run++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    tests_run++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests_run++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", locked); end
  endtask

  task automatic test_normal();
    logic [31:0] cl, cr;
    int rx0, fe0;
    do_reset();
    tx_left = 24'h123456;
    tx_right = 24'habcdef;
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    send_frame(24'h654321, 24'hfedcba, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL normal_locked: got %b expected 1", locked); end
    tests_run++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL normal_partial_discard: got %0d pulses expected 0", rx_cnt - rx0); end
    send_frame(24'h654321, 24'hfedcba, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL normal_rx_count: got %0d expected 1", rx_cnt - rx0); end
    tests_run++; if (rx_left !== 24'h654321) begin fails++; $display("FAIL normal_rx_left: got %h expected 654321", rx_left); end
    tests_run++; if (rx_right !== 24'hfedcba) begin fails++; $display("FAIL normal_rx_right: got %h expected fedcba", rx_right); end
    tests_run++; if (ferr_cnt - fe0 !== 0) begin fails++; $display("FAIL normal_no_frame_err: got %0d expected 0", ferr_cnt - fe0); end
  endtask

  task automatic test_transmit();
    logic [31:0] cl, cr;
    int ack0, rx0;
    ack0 = ack_cnt;
    rx0 = rx_cnt;
    for (int f = 0; f < 2; f++) begin
      send_frame(24'h0c0c0c, 24'h303030, cl, cr);
      tests_run++; if (cl !== 32'h12345600) begin fails++; $display("FAIL tx_left_slot%0d: got %h expected 12345600", f, cl); end
      tests_run++; if (cr !== 32'habcdef00) begin fails++; $display("FAIL tx_right_slot%0d: got %h expected abcdef00", f, cr); end
    end
    repeat (8) @(negedge clock);
    tests_run++; if (ack_cnt - ack0 !== 2) begin fails++; $display("FAIL tx_ack_count: got %0d expected 2", ack_cnt - ack0); end
    tests_run++; if (rx_cnt - rx0 !== 2) begin fails++; $display("FAIL tx_rx_count: got %0d expected 2", rx_cnt - rx0); end
    tests_run++; if (rx_left !== 24'h0c0c0c) begin fails++; $display("FAIL tx_rx_left: got %h expected 0c0c0c", rx_left); end
  endtask

  task automatic test_short_slot();
    logic [31:0] cl, cr;
    int rx0, fe0;
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    send_slot(1'b0, 24'h111111, 30, cl);
    send_slot(1'b1, 24'h222222, 32, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (ferr_cnt - fe0 !== 1) begin fails++; $display("FAIL short_frame_err: got %0d expected 1", ferr_cnt - fe0); end
    tests_run++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL short_no_rx: got %0d expected 0", rx_cnt - rx0); end
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL short_stays_locked: got %b expected 1", locked); end
    send_frame(24'h800001, 24'h7ffffe, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL short_rx_after1: got %0d expected 1", rx_cnt - rx0); end
    tests_run++; if (rx_left !== 24'h800001) begin fails++; $display("FAIL short_rx_left1: got %h expected 800001", rx_left); end
    tests_run++; if (rx_right !== 24'h7ffffe) begin fails++; $display("FAIL short_rx_right1: got %h expected 7ffffe", rx_right); end
    send_frame(24'h0f0f0f, 24'hf0f0f0, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (rx_cnt - rx0 !== 2) begin fails++; $display("FAIL short_rx_after2: got %0d expected 2", rx_cnt - rx0); end
    tests_run++; if (rx_left !== 24'h0f0f0f) begin fails++; $display("FAIL short_rx_left2: got %h expected 0f0f0f", rx_left); end
    tests_run++; if (rx_right !== 24'hf0f0f0) begin fails++; $display("FAIL short_rx_right2: got %h expected f0f0f0", rx_right); end
    tests_run++; if (ferr_cnt - fe0 !== 1) begin fails++; $display("FAIL short_no_extra_err: got %0d expected 1", ferr_cnt - fe0); end
  endtask

  task automatic test_stuck();
    logic [31:0] cl, cr;
    logic c;
    logic any_dout;
    int fe0, rx0;
    do_reset();
    tx_left = 24'h123456;
    tx_right = 24'habcdef;
    send_frame(24'h0, 24'h0, cl, cr);
    fe0 = ferr_cnt;
    for (int k = 1; k <= 62; k++) bclk_cycle(1'b0, 1'b1, c);
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL stuck_locked_before: got %b expected 1", locked); end
    tests_run++; if (ferr_cnt - fe0 !== 0) begin fails++; $display("FAIL stuck_early_err: got %0d expected 0", ferr_cnt - fe0); end
    bclk_cycle(1'b0, 1'b1, c);
    tests_run++; if (ferr_cnt - fe0 !== 1) begin fails++; $display("FAIL stuck_frame_err: got %0d expected 1", ferr_cnt - fe0); end
    tests_run++; if (locked !== 1'b0) begin fails++; $display("FAIL stuck_unlocked: got %b expected 0", locked); end
    any_dout = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bclk_cycle(1'b0, 1'b1, c);
      any_dout = any_dout | c;
    end
    tests_run++; if (any_dout !== 1'b0) begin fails++; $display("FAIL stuck_dout_zero: got %b expected 0", any_dout); end
    rx0 = rx_cnt;
    bclk_cycle(1'b1, 1'b0, c);
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL stuck_relock: got %b expected 1", locked); end
    send_slot(1'b1, 24'h0, 32, cr);
    tests_run++; if (cr !== 32'h0) begin fails++; $display("FAIL stuck_tx_hold_cleared: got %h expected 0", cr); end
    send_frame(24'habc123, 24'h456def, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (cl !== 32'h12345600) begin fails++; $display("FAIL stuck_tx_left_after: got %h expected 12345600", cl); end
    tests_run++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL stuck_rx_count: got %0d expected 1", rx_cnt - rx0); end
    tests_run++; if (rx_right !== 24'h456def) begin fails++; $display("FAIL stuck_rx_right: got %h expected 456def", rx_right); end
  endtask

  task automatic test_startup();
    logic [31:0] cl, cr;
    logic c;
    int rx0, fe0;
    do_reset();
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    for (int i = 0; i < 16; i++) bclk_cycle((i == 15) ? 1'b0 : 1'b1, i[0], c);
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL startup_locked: got %b expected 1", locked); end
    tests_run++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL startup_no_rx: got %0d expected 0", rx_cnt - rx0); end
    send_frame(24'h112233, 24'h445566, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL startup_rx_count: got %0d expected 1", rx_cnt - rx0); end
    tests_run++; if (rx_left !== 24'h112233) begin fails++; $display("FAIL startup_rx_left: got %h expected 112233", rx_left); end
    tests_run++; if (rx_right !== 24'h445566) begin fails++; $display("FAIL startup_rx_right: got %h expected 445566", rx_right); end
    tests_run++; if (ferr_cnt - fe0 !== 0) begin fails++; $display("FAIL startup_no_err: got %0d expected 0", ferr_cnt - fe0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] cl, cr;
    logic c;
    int rx0;
    do_reset();
    tx_left = 24'h123456;
    tx_right = 24'habcdef;
    send_frame(24'h0, 24'h0, cl, cr);
    send_frame(24'h5a5a5a, 24'ha5a5a5, cl, cr);
    send_slot(1'b0, 24'h777777, 32, cl);
    for (int i = 0; i < 8; i++) bclk_cycle(1'b1, 1'b1, c);
    #33;
    tests_run++; if (dout !== 1'b1) begin fails++; $display("FAIL mid_dout_before: got %b expected 1", dout); end
    rx0 = rx_cnt;
    reset = 1'b1;
    #1;
    tests_run++; if (rx_left !== 24'h0) begin fails++; $display("FAIL mid_rx_left_async: got %h expected 0", rx_left); end
    tests_run++; if (rx_right !== 24'h0) begin fails++; $display("FAIL mid_rx_right_async: got %h expected 0", rx_right); end
    tests_run++; if (dout !== 1'b0) begin fails++; $display("FAIL mid_dout_async: got %b expected 0", dout); end
    tests_run++; if (locked !== 1'b0) begin fails++; $display("FAIL mid_locked_async: got %b expected 0", locked); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 23; i++) bclk_cycle(1'b1, 1'b1, c);
    tests_run++; if (locked !== 1'b0) begin fails++; $display("FAIL mid_still_hunting: got %b expected 0", locked); end
    bclk_cycle(1'b0, 1'b0, c);
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL mid_relock: got %b expected 1", locked); end
    tests_run++; if (rx_cnt - rx0 !== 0) begin fails++; $display("FAIL mid_no_spurious_rx: got %0d expected 0", rx_cnt - rx0); end
    send_frame(24'hc3c3c3, 24'h3c3c3c, cl, cr);
    repeat (8) @(negedge clock);
    tests_run++; if (rx_cnt - rx0 !== 1) begin fails++; $display("FAIL mid_rx_count: got %0d expected 1", rx_cnt - rx0); end
    tests_run++; if (rx_left !== 24'hc3c3c3) begin fails++; $display("FAIL mid_rx_left: got %h expected c3c3c3", rx_left); end
    tests_run++; if (rx_right !== 24'h3c3c3c) begin fails++; $display("FAIL mid_rx_right: got %h expected 3c3c3c", rx_right); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_transmit();
    test_short_slot();
    test_stuck();
    test_startup();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/i2s_ext_slave.md
Name: i2s_ext_slave

Overview:
- Far-end I2S peripheral: consumes the BCLK/LRCLK pair driven by the transceiver's I2S clock generator.
- Deserialises the transceiver's DOUT (24-bit RX I/Q, MSB first, 32-bit slots) into parallel left/right words.
- Serialises parallel TX words onto the line feeding the transceiver's DIN.
- Runs entirely in one fast system clock domain by oversampling the I2S pins.
- Used as the MCU/codec-side model and as the companion block for board bring-up and loopback.

Parameters:
DATA_W, 24, data bits per slot, MSB first; must be ≤ SLOT_W
SLOT_W, 32, BCLK cycles per LRCLK half-period

Ports:
clock  in  1  system clock; must be ≥ 8× BCLK frequency
reset  in  1  asynchronous, active-high
bclk  in  1  I2S bit clock from the transceiver
lrclk  in  1  I2S word select; low = left slot, high = right slot
din  in  1  serial data from the transceiver's DOUT
dout  out  1  serial data to the transceiver's DIN
tx_left  in  DATA_W  left word to transmit
tx_right  in  DATA_W  right word to transmit
tx_ack  out  1  one-cycle pulse: tx_left/tx_right latched
rx_left  out  DATA_W  last received left word
rx_right  out  DATA_W  last received right word
rx_valid  out  1  one-cycle pulse: new rx_left/rx_right pair
frame_err  out  1  one-cycle pulse: slot-length violation
locked  out  1  high while in RUN

Behaviour:
- Reset values: dout=0, tx_ack=0, rx_left=0, rx_right=0, rx_valid=0, frame_err=0, locked=0, state=HUNT, bit_cnt=0, left_staged=0.
- Input synchronisation:
  - bclk, lrclk and din each pass through a 2-FF synchroniser of equal depth.
  - Edge detection on synchronised bclk yields single-cycle rise and fall strobes.
- Rising-edge processing (rise strobe):
  - Sample ws = synced lrclk and bit = synced din.
  - ws_chg = (ws != ws_prev); ws_prev <= ws.
  - The rising edge on which ws_chg is seen carries slot position SLOT_W-1 of the previous slot.
  - Position 0 (MSB) of the new slot is sampled on the next rising edge.
- State HUNT:
  - din is ignored; dout is held 0.
  - First ws_chg → RUN, bit_cnt=0. No word is emitted.
- State RUN, rise without ws_chg:
  - If bit_cnt < DATA_W, shift bit into rx_shift (MSB first).
  - bit_cnt increments.
  - If bit_cnt reaches 2*SLOT_W-1 (LRCLK stuck): frame_err pulse, left_staged=0 → HUNT.
- State RUN, rise with ws_chg:
  - Valid slot requires bit_cnt == SLOT_W-1; bit_cnt is then cleared to 0.
  - Previous ws=0 (left slot ended): copy rx_shift to left_hold, set left_staged=1.
  - Previous ws=1 (right slot ended) with left_staged=1: next cycle rx_left<=left_hold, rx_right<=rx_shift, rx_valid pulses; left_staged=0.
  - Previous ws=1 with left_staged=0: word discarded, no pulse.
  - Invalid slot (bit_cnt != SLOT_W-1): frame_err pulse, left_staged=0, stay in RUN, bit_cnt=0 (resynchronise on this edge).
- Transmit:
  - On a ws_chg rising edge where the new ws=0 (left slot start), tx_left/tx_right are latched into tx_hold and tx_ack pulses in the same cycle.
  - This latch happens even if the edge raises frame_err.
  - On each fall strobe in RUN: dout = tx_hold word for the current ws, bit index DATA_W-1-bit_cnt when bit_cnt < DATA_W, else 0.
  - After a ws_chg, the first falling edge therefore drives the MSB.
  - Until the first left-slot latch after entering RUN, tx_hold is 0.
- Latency:
  - dout updates ≤ 4 clock cycles after the physical bclk falling edge.
  - rx_valid asserts ≤ 5 cycles after the bclk rise that ends the right slot.
- Simultaneous events: a rise strobe and a fall strobe in the same cycle cannot occur given the clock ratio; no handling is defined.
- Reset mid-frame: all state clears immediately (async); after release the block returns to HUNT and the partial frame is never emitted.
- locked = (state == RUN).

Test Plan:
- Normal frame: 64-BCLK frames, left=24'h654321, right=24'hfedcba → after the first discarded partial frame, rx_valid once per frame with rx_left=654321, rx_right=fedcba; frame_err=0.
- Transmit: tx_left=24'h123456, tx_right=24'habcdef held constant → tx_ack once per frame; captured dout decodes to 123456/abcdef, with bits 24..31 of each slot = 0.
- Short slot: one slot of 30 BCLKs injected → one frame_err pulse, no rx_valid for that frame; the next two correct frames yield correct rx_valid data.
- Stuck LRCLK: LRCLK held low for 70 BCLKs → frame_err at bit_cnt 63, locked→0; dout=0 until LRCLK toggles again, then locked→1.
- Startup alignment: stream starts mid right slot → no rx_valid until a full left+right pair is seen; the first valid pair is correct.
- Reset mid-frame: assert reset at BCLK 40 of a frame → all outputs 0 asynchronously, no spurious rx_valid; lock reacquired on the first LRCLK edge after release.
